// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter output oStallCnt is built when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [CTRL_W-1:0] iCtrl,
  input  logic [DATA_W-1:0] iData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [CTRL_W-1:0] oCtrl,
  output logic [DATA_W-1:0] oData,
  output logic [1:0]        oOccupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  oStallCnt
`endif
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CTRL_W-1:0] head_ctrl_reg, skid_ctrl_reg;
  logic [DATA_W-1:0] head_data_reg, skid_data_reg;

  logic accept, release_head;
  logic head_load, head_from_skid, skid_load;

  assign accept       = iValid & (state_reg != FULL);
  assign release_head = (state_reg != EMPTY) & iReady;

  always_comb begin
    state_next     = state_reg;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (iFlush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && release_head) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (release_head) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (release_head) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Flush clears control only; data registers keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
      head_data_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      if (iFlush) begin
        head_ctrl_reg <= '0;
        skid_ctrl_reg <= '0;
      end else begin
        if (head_load) begin
          head_ctrl_reg <= head_from_skid ? skid_ctrl_reg : iCtrl;
          head_data_reg <= head_from_skid ? skid_data_reg : iData;
        end
        if (skid_load) begin
          skid_ctrl_reg <= iCtrl;
          skid_data_reg <= iData;
        end
      end
    end
  end

  assign oValid     = (state_reg != EMPTY);
  assign oReady     = (state_reg != FULL) & rst_n;
  assign oCtrl      = oValid ? head_ctrl_reg : '0;
  assign oData      = head_data_reg;
  assign oOccupancy = state_reg;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (oValid && !iReady && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign oStallCnt = stall_cnt_reg;
`else
  // CNT_W only sizes the stall counter, which is absent in this build.
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based FIFO model.
// Exercises the stall counter as well when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam int NW = 4;
`else
  localparam int NW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iValid, oReady, iFlush, oValid, iReady;
  logic [CW-1:0] iCtrl, oCtrl;
  logic [DW-1:0] iData, oData;
  logic [1:0]    oOccupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [NW-1:0] oStallCnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iValid(iValid), .oReady(oReady), .iCtrl(iCtrl), .iData(iData), .iFlush(iFlush),
    .oValid(oValid), .iReady(iReady), .oCtrl(oCtrl), .oData(oData), .oOccupancy(oOccupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .oStallCnt(oStallCnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the stage is a FIFO of at most 2 {ctrl,data} entries.
  logic [CW+DW-1:0] exp_q[$];
  logic [DW-1:0]    exp_last;

  function automatic logic [CW-1:0] m_ctrl();
    logic [CW+DW-1:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[CW+DW-1:DW];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_last = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    int sz;
    logic [CW+DW-1:0] e;
    iValid = v; iCtrl = c; iData = d; iReady = r; iFlush = f;
    @(posedge clk);
    sz = exp_q.size();
    if (f) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && r) void'(exp_q.pop_front());
      if (v && sz < 2) exp_q.push_back({c, d});
    end
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      exp_last = e[DW-1:0];
    end
    @(negedge clk);
    iValid = 1'b0; iFlush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iValid = 0; iReady = 0; iFlush = 0; iCtrl = '0; iData = '0;
    repeat (3) @(negedge clk);
    model_reset();
    n_checks += 5;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", oValid); end
    if (oReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", oReady); end
    if (oCtrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got %h want 00", oCtrl); end
    if (oData !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", oData); end
    if (oOccupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", oOccupancy); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (oReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", oReady); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, CW'(8'h10 + i), DW'(i), 1'b1, 1'b0);
      n_checks += 5;
      if (oValid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, oValid); end
      if (oData !== DW'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, oData, i); end
      if (oCtrl !== CW'(8'h10 + i)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %h want %h", i, oCtrl, 8'h10 + i); end
      if (oReady !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, oReady); end
      if (oOccupancy > 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want <=1", i, oOccupancy); end
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks += 3;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got %b want 0", oValid); end
    if (oCtrl !== '0) begin n_fail++; $display("FAIL stream_bubble_ctrl got %h want 00", oCtrl); end
    if (oData !== DW'(5)) begin n_fail++; $display("FAIL stream_hold_data got %h want 5", oData); end
    $display("test_stream done");
  endtask

  task automatic test_stall_fill();
    cycle(1'b1, 8'hA1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 8'hB1, 32'hB, 1'b0, 1'b0);
    n_checks += 3;
    if (oOccupancy !== 2'd2) begin n_fail++; $display("FAIL fill_occ got %0d want 2", oOccupancy); end
    if (oReady !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", oReady); end
    if (oData !== 32'hA) begin n_fail++; $display("FAIL fill_head got %h want a", oData); end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks += 3;
    if (oData !== 32'hB) begin n_fail++; $display("FAIL fill_second got %h want b", oData); end
    if (oCtrl !== 8'hB1) begin n_fail++; $display("FAIL fill_second_ctrl got %h want b1", oCtrl); end
    if (oReady !== 1'b1) begin n_fail++; $display("FAIL fill_ready_back got %b want 1", oReady); end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (oOccupancy !== 2'd0) begin n_fail++; $display("FAIL fill_drain_occ got %0d want 0", oOccupancy); end
    $display("test_stall_fill done");
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'hA2, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 8'hCC, 32'hC, 1'b0, 1'b1);
    n_checks += 3;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", oValid); end
    if (oCtrl !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl got %h want 00", oCtrl); end
    if (oOccupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", oOccupancy); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (oValid !== 1'b0 || oData === 32'hC)
        begin n_fail++; $display("FAIL flush_leak[%0d] got valid=%b data=%h want valid=0 data!=c", k, oValid, oData); end
    end
    $display("test_flush done");
  endtask

  task automatic test_accept_release();
    cycle(1'b1, 8'h31, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 32'h20, 1'b1, 1'b0);
    n_checks += 2;
    if (oData !== 32'h20) begin n_fail++; $display("FAIL ar_data got %h want 20", oData); end
    if (oOccupancy !== 2'd1) begin n_fail++; $display("FAIL ar_occ got %0d want 1", oOccupancy); end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    $display("test_accept_release done");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_fail;
    for (int t = 0; t < 400; t++) begin
      cycle($urandom_range(0, 3) != 0, CW'($urandom), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      n_checks += 5;
      if (oValid !== (exp_q.size() > 0))
        begin n_fail++; $display("FAIL rand_valid[%0d] got %b want %b", t, oValid, exp_q.size() > 0); end
      if (oReady !== (exp_q.size() < 2))
        begin n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", t, oReady, exp_q.size() < 2); end
      if (oCtrl !== m_ctrl())
        begin n_fail++; $display("FAIL rand_ctrl[%0d] got %h want %h", t, oCtrl, m_ctrl()); end
      if (oData !== exp_last)
        begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", t, oData, exp_last); end
      if (oOccupancy !== 2'(exp_q.size()))
        begin n_fail++; $display("FAIL rand_occ[%0d] got %0d want %0d", t, oOccupancy, exp_q.size()); end
    end
    $display("test_random done, %0d new failures", n_fail - errs_before);
  endtask

  task automatic test_async_reset();
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h41, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 32'h2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", oValid); end
    if (oReady !== 1'b0) begin n_fail++; $display("FAIL async_ready got %b want 0", oReady); end
    if (oCtrl !== '0) begin n_fail++; $display("FAIL async_ctrl got %h want 00", oCtrl); end
    if (oOccupancy !== 2'd0) begin n_fail++; $display("FAIL async_occ got %0d want 0", oOccupancy); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h55, 32'h5, 1'b1, 1'b0);
    n_checks++;
    if (oValid !== 1'b1 || oData !== 32'h5)
      begin n_fail++; $display("FAIL async_restart got valid=%b data=%h want valid=1 data=5", oValid, oData); end
    $display("test_async_reset done");
  endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_checks++;
    if (oStallCnt !== '0) begin n_fail++; $display("FAIL cnt_reset got %0d want 0", oStallCnt); end
    cycle(1'b1, 8'h66, 32'h6, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      if (k == 5 || k == 20) begin
        n_checks++;
        if (oStallCnt !== NW'(k > 15 ? 15 : k))
          begin n_fail++; $display("FAIL cnt_stall[%0d] got %0d want %0d", k, oStallCnt, k > 15 ? 15 : k); end
      end
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++;
    if (oStallCnt !== 4'd15) begin n_fail++; $display("FAIL cnt_after_flush got %0d want 15", oStallCnt); end
    $display("test_stall_cnt done");
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_accept_release();
    test_random();
    test_async_reset();
`ifdef PIPE_STAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
